// File: rtl/game_pkg.sv
// Shared definitions for the game tick scheduler: state encodings, board clock rate,
// default divider constants and the level-to-period helper.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam int CLK_HZ          = 50_000_000;
    localparam int BASE_DIV_DEF    = 5_000_000;
    localparam int STEP_DIV_DEF    = 500_000;
    localparam int MIN_DIV_DEF     = 1_000_000;
    localparam int LEVEL_TICKS_DEF = 100;
    localparam int MAX_LEVEL_DEF   = 7;
    localparam int SEC_DIV_DEF     = CLK_HZ;

    // Signed arithmetic so a large level never wraps below the floor.
    function automatic logic [31:0] calc_div(input int lvl, input int base_div,
                                             input int step_div, input int min_div);
        int d;
        d = base_div - lvl * step_div;
        return (d < min_div) ? 32'(min_div) : 32'(d);
    endfunction

endpackage

// File: rtl/game_tick_sched_tick_counter.sv
// Enable counter 0..term with synchronous clear; done marks the wrapping cycle.
module tick_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic         done
);

    logic [W-1:0] count_reg;

    assign done = en && !clr && (count_reg == term);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= done ? '0 : count_reg + W'(1);
        end
    end

endmodule

// File: rtl/game_tick_sched.sv
// Game-rate scheduler: idle/run/pause control, level-scaled tick enables.
// Optional 1 Hz sec_pulse output when TICK_SCHED_SEC_EN is defined.
module game_tick_sched
    import game_pkg::*;
#(
    parameter int BASE_DIV    = BASE_DIV_DEF,
    parameter int STEP_DIV    = STEP_DIV_DEF,
    parameter int MIN_DIV     = MIN_DIV_DEF,
    parameter int LEVEL_TICKS = LEVEL_TICKS_DEF,
    parameter int MAX_LEVEL   = MAX_LEVEL_DEF,
    parameter int SEC_DIV     = SEC_DIV_DEF,
    localparam int LW         = $clog2(MAX_LEVEL + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    output logic          tick,
    output logic [LW-1:0] level,
    output logic [1:0]    state
`ifdef TICK_SCHED_SEC_EN
    ,
    output logic          sec_pulse
`endif
);

    state_t        state_reg, state_next;
    logic          tick_reg;
    logic [LW-1:0] level_reg;
    logic [31:0]   div_reg;
    logic          run_now;
    logic          cnt_clr;
    logic          period_done;
    logic          level_up;

    assign run_now = (state_reg == ST_RUN);
    // Counters sit at zero throughout IDLE, so a start always begins a fresh period.
    assign cnt_clr = stop || (state_reg == ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = ST_IDLE;
        end else if (start && state_reg == ST_IDLE) begin
            state_next = ST_RUN;
        end else if (pause && state_reg == ST_RUN) begin
            state_next = ST_PAUSE;
        end else if (pause && state_reg == ST_PAUSE) begin
            state_next = ST_RUN;
        end
    end

    tick_counter #(.W(32)) u_period (
        .clk   (clk),
        .reset (reset),
        .en    (run_now),
        .clr   (cnt_clr),
        .term  (div_reg - 32'd1),
        .done  (period_done)
    );

    tick_counter #(.W(32)) u_level_ticks (
        .clk   (clk),
        .reset (reset),
        .en    (period_done),
        .clr   (cnt_clr),
        .term  (32'(LEVEL_TICKS - 1)),
        .done  (level_up)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_reg  <= 1'b0;
            level_reg <= '0;
            div_reg   <= 32'(BASE_DIV);
        end else begin
            tick_reg <= period_done;
            if (cnt_clr) begin
                level_reg <= '0;
            end else if (level_up && level_reg != LW'(MAX_LEVEL)) begin
                level_reg <= level_reg + LW'(1);
            end
            // One cycle behind level; the period counter is at least 1 by then, so
            // the new divider only governs the period that just began.
            if (cnt_clr) begin
                div_reg <= 32'(BASE_DIV);
            end else begin
                div_reg <= calc_div(int'(level_reg), BASE_DIV, STEP_DIV, MIN_DIV);
            end
        end
    end

    assign tick  = tick_reg;
    assign level = level_reg;
    assign state = state_reg;

`ifdef TICK_SCHED_SEC_EN
    logic sec_done;
    logic sec_pulse_reg;

    tick_counter #(.W(32)) u_sec (
        .clk   (clk),
        .reset (reset),
        .en    (run_now),
        .clr   (cnt_clr),
        .term  (32'(SEC_DIV - 1)),
        .done  (sec_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_pulse_reg <= 1'b0;
        end else begin
            sec_pulse_reg <= sec_done;
        end
    end

    assign sec_pulse = sec_pulse_reg;
`else
    // Seconds timebase not built in this configuration.
`endif

endmodule

// File: tb/tb_game_tick_sched.sv
// Self-checking bench for game_tick_sched: directed steps plus random control pulses,
// checked every cycle against a period/elapsed-time reference model.
module tb_game_tick_sched;

    localparam int BASE  = 10;
    localparam int STEP  = 2;
    localparam int MIN   = 4;
    localparam int LTICK = 3;
    localparam int MAXL  = 7;
    localparam int SECD  = 20;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       tick;
    logic [2:0] level;
    logic [1:0] state;
`ifdef TICK_SCHED_SEC_EN
    logic       sec_pulse;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int m_state, m_level, m_elapsed, m_ticks, m_sec_el;
    int m_tick, m_sec;

    game_tick_sched #(
        .BASE_DIV    (BASE),
        .STEP_DIV    (STEP),
        .MIN_DIV     (MIN),
        .LEVEL_TICKS (LTICK),
        .MAX_LEVEL   (MAXL),
        .SEC_DIV     (SECD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .pause (pause),
        .tick  (tick),
        .level (level),
        .state (state)
`ifdef TICK_SCHED_SEC_EN
        ,
        .sec_pulse (sec_pulse)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int div_of(input int l);
        int d;
        d = BASE - l * STEP;
        return (d < MIN) ? MIN : d;
    endfunction

    task automatic model_reset();
        m_state = 0; m_level = 0; m_elapsed = 0; m_ticks = 0; m_sec_el = 0;
        m_tick = 0; m_sec = 0;
    endtask

    task automatic model_clear_play();
        m_level = 0; m_elapsed = 0; m_ticks = 0; m_sec_el = 0;
    endtask

    task automatic model_step(input logic s_start, input logic s_stop, input logic s_pause);
        m_tick = 0;
        m_sec  = 0;
        if (s_stop) begin
            m_state = 0;
            model_clear_play();
        end else if (s_start && m_state == 0) begin
            m_state = 1;
            model_clear_play();
        end else begin
            if (m_state == 1) begin
                m_elapsed++;
                if (m_elapsed == div_of(m_level)) begin
                    m_tick = 1;
                    m_elapsed = 0;
                    m_ticks++;
                    if (m_ticks == LTICK) begin
                        m_ticks = 0;
                        if (m_level < MAXL) m_level++;
                    end
                end
                m_sec_el++;
                if (m_sec_el == SECD) begin
                    m_sec = 1;
                    m_sec_el = 0;
                end
            end
            if (s_pause && m_state == 1) m_state = 2;
            else if (s_pause && m_state == 2) m_state = 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (tick === m_tick[0]) else begin
            errors++;
            $error("FAIL %s tick cyc=%0d got=%b exp=%0d", tag, cyc, tick, m_tick);
        end
        checks++;
        assert (level === 3'(m_level)) else begin
            errors++;
            $error("FAIL %s level cyc=%0d got=%0d exp=%0d", tag, cyc, level, m_level);
        end
        checks++;
        assert (state === 2'(m_state)) else begin
            errors++;
            $error("FAIL %s state cyc=%0d got=%0d exp=%0d", tag, cyc, state, m_state);
        end
`ifdef TICK_SCHED_SEC_EN
        checks++;
        assert (sec_pulse === m_sec[0]) else begin
            errors++;
            $error("FAIL %s sec_pulse cyc=%0d got=%b exp=%0d", tag, cyc, sec_pulse, m_sec);
        end
`endif
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
        $display("step %s: got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic cycle(input logic s_start, input logic s_stop, input logic s_pause);
        @(negedge clk);
        start = s_start;
        stop  = s_stop;
        pause = s_pause;
        @(posedge clk);
        model_step(s_start, s_stop, s_pause);
        #1;
        cyc++;
        check_outputs("cyc");
    endtask

    task automatic run_until_tick(output int n);
        n = 0;
        do begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end while (tick !== 1'b1 && n < 200);
    endtask

    initial begin
        int n;
        int seen;
        start = 1'b0; stop = 1'b0; pause = 1'b0; reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_outputs("reset");
        @(negedge clk) reset = 1'b1;
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        // Start, first tick 10 cycles later, then the level ramp down to the floor.
        cycle(1, 0, 0);
        check_val("start_state", int'(state), 1);
        run_until_tick(n);
        check_val("first_tick", n, 10);
        run_until_tick(n);
        check_val("tick_gap_1", n, 10);
        for (int k = 2; k < 27; k++) begin
            run_until_tick(n);
            check_val($sformatf("tick_gap_%0d", k), n, div_of((k / LTICK > MAXL) ? MAXL : k / LTICK));
        end
        check_val("level_sat", int'(level), 7);

        // Pause with 5 cycles of the period remaining, hold 50 cycles, resume.
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        repeat (4) cycle(0, 0, 0);
        cycle(0, 0, 1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(0, 0, 0);
            if (tick === 1'b1) seen++;
        end
        check_val("pause_no_tick", seen, 0);
        check_val("pause_state", int'(state), 2);
        cycle(0, 0, 1);
        run_until_tick(n);
        check_val("resume_gap", n, 5);

        // Stop+pause together wins to IDLE; start while running is ignored.
        cycle(0, 1, 1);
        check_val("stop_state", int'(state), 0);
        check_val("stop_tick", int'(tick), 0);
        cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 0);
        cycle(1, 0, 0);
        run_until_tick(n);
        check_val("start_in_run_gap", n, 6);
        run_until_tick(n);
        run_until_tick(n);
        check_val("level_one", int'(level), 1);

        // Asynchronous reset mid-period.
        repeat (3) cycle(0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_val("async_state", int'(state), 0);
        check_val("async_level", int'(level), 0);
        check_val("async_tick", int'(tick), 0);
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        cycle(1, 0, 0);
        run_until_tick(n);
        check_val("post_reset_first_tick", n, 10);

`ifdef TICK_SCHED_SEC_EN
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        n = 0;
        do begin
            cycle(0, 0, 0);
            n++;
        end while (sec_pulse !== 1'b1 && n < 200);
        check_val("sec_first", n, 20);
`endif

        // Random control pulses, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
